// File: rtl/fir_pkg.sv
// Shared definitions for the pulse-shaping FIR sequencer: state encodings,
// symbol format defaults and the FIR pipeline latency shared with the FIR instance.
package fir_pkg;

  localparam logic [3:0] ST_IDLE  = 4'b0001;
  localparam logic [3:0] ST_RUN   = 4'b0010;
  localparam logic [3:0] ST_FLUSH = 4'b0100;
  localparam logic [3:0] ST_DRAIN = 4'b1000;

  typedef enum logic [3:0] {
    IDLE  = ST_IDLE,
    RUN   = ST_RUN,
    FLUSH = ST_FLUSH,
    DRAIN = ST_DRAIN
  } state_e;

  localparam int SYMBOL_WIDTH_DEF = 16;
  localparam int SYMBOL_FRAC_DEF  = 14;
  localparam int FIR_LATENCY_DEF  = 3;

endpackage

// File: rtl/fir_strobe_gen.sv
// Clock divider for the FIR sample strobe: counts 0..CLK_DIV-1 while enabled,
// held at zero by a synchronous clear so the first strobe lands CLK_DIV cycles in.
module fir_strobe_gen
  import fir_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic strobe_o
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_TOP = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q, div_d;

  always_comb begin
    div_d = div_q;
    if (clr_i) begin
      div_d = '0;
    end else if (en_i) begin
      div_d = (div_q == DIV_TOP) ? '0 : div_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign strobe_o = en_i && !clr_i && (div_q == DIV_TOP);

endmodule

// File: rtl/fir_sched.sv
// Sequencer for the BPSK pulse-shaping FIR: zero-stuffs symbols, flushes and drains
// the filter at burst end, and flags valid FIR outputs. FIR_SCHED_STATS_EN adds counters.
module fir_sched
  import fir_pkg::*;
#(
  parameter int SYMBOL_WIDTH = SYMBOL_WIDTH_DEF,
  parameter int CLK_DIV      = 4,
  parameter int UPSAMPLE     = 4,
  parameter int FILT_TAPS    = 8,
  parameter int FIR_LATENCY  = FIR_LATENCY_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           s_valid,
  input  logic signed [SYMBOL_WIDTH-1:0] s_data,
  input  logic                           s_last,
  output logic                           s_ready,
  output logic                           fir_en,
  output logic                           fir_new_sample,
  output logic signed [SYMBOL_WIDTH-1:0] fir_sample,
  output logic                           m_valid,
  output logic                           busy,
  output logic                           underflow
`ifdef FIR_SCHED_STATS_EN
  ,
  output logic [31:0]                    sym_count,
  output logic [15:0]                    underflow_count
`endif
);

  localparam int PH_W    = $clog2(UPSAMPLE + 1);
  localparam int CNT_MAX = (FILT_TAPS > FIR_LATENCY) ? FILT_TAPS : FIR_LATENCY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int SC_W    = $clog2(FIR_LATENCY + 1);

  state_e                         state_q, state_d;
  logic                           hold_valid_q, hold_valid_d;
  logic                           hold_last_q, hold_last_d;
  logic signed [SYMBOL_WIDTH-1:0] hold_data_q, hold_data_d;
  logic                           cur_last_q, cur_last_d;
  logic [PH_W-1:0]                phase_q, phase_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [SC_W-1:0]                strb_cnt_q, strb_cnt_d;
  logic                           underflow_q, underflow_d;
  logic signed [SYMBOL_WIDTH-1:0] sample_q, sample_d;
  logic                           nsmp_q;
  logic                           vld_p1_q, vld_p2_q;
  logic                           strobe, take, last_eff;

  fir_strobe_gen #(.CLK_DIV(CLK_DIV)) u_strobe (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (state_q != IDLE),
    .clr_i    (state_q == IDLE),
    .strobe_o (strobe)
  );

  always_comb begin
    state_d      = state_q;
    hold_valid_d = hold_valid_q;
    hold_last_d  = hold_last_q;
    hold_data_d  = hold_data_q;
    cur_last_d   = cur_last_q;
    phase_d      = phase_q;
    cnt_d        = cnt_q;
    strb_cnt_d   = strb_cnt_q;
    underflow_d  = underflow_q;
    sample_d     = sample_q;
    take         = 1'b0;
    // With UPSAMPLE==1 the phase-0 strobe is also the last one, so use the symbol being taken.
    last_eff     = (phase_q == '0) ? (hold_valid_q && hold_last_q) : cur_last_q;
    unique case (state_q)
      IDLE: begin
        phase_d    = '0;
        cnt_d      = '0;
        strb_cnt_d = '0;
        if (hold_valid_q) state_d = RUN;
      end
      RUN: if (strobe) begin
        sample_d = '0;
        if (phase_q == '0) begin
          if (hold_valid_q) begin
            sample_d   = hold_data_q;
            take       = 1'b1;
            cur_last_d = hold_last_q;
          end else begin
            underflow_d = 1'b1;
            cur_last_d  = 1'b0;
          end
        end
        if (phase_q == PH_W'(UPSAMPLE - 1)) begin
          phase_d = '0;
          if (last_eff) begin
            state_d = FLUSH;
            cnt_d   = '0;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      FLUSH: if (strobe) begin
        sample_d = '0;
        if (cnt_q == CNT_W'(FILT_TAPS - 1)) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: if (strobe) begin
        sample_d = '0;
        if (cnt_q == CNT_W'(FIR_LATENCY - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (strobe && (strb_cnt_q != SC_W'(FIR_LATENCY))) strb_cnt_d = strb_cnt_q + 1'b1;
    if (take) hold_valid_d = 1'b0;
    if (s_valid && !hold_valid_q) begin
      hold_valid_d = 1'b1;
      hold_data_d  = s_data;
      hold_last_d  = s_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hold_valid_q <= 1'b0;
      hold_last_q  <= 1'b0;
      hold_data_q  <= '0;
      cur_last_q   <= 1'b0;
      phase_q      <= '0;
      cnt_q        <= '0;
      strb_cnt_q   <= '0;
      underflow_q  <= 1'b0;
      sample_q     <= '0;
      nsmp_q       <= 1'b0;
      vld_p1_q     <= 1'b0;
      vld_p2_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_valid_q <= hold_valid_d;
      hold_last_q  <= hold_last_d;
      hold_data_q  <= hold_data_d;
      cur_last_q   <= cur_last_d;
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      strb_cnt_q   <= strb_cnt_d;
      underflow_q  <= underflow_d;
      // Stage 1: sample strobe registered alongside its data
      sample_q     <= sample_d;
      nsmp_q       <= strobe;
      vld_p1_q     <= strobe && (strb_cnt_q == SC_W'(FIR_LATENCY));
      // Stage 2: lines up with the FIR o_sample register; dropped once back in IDLE
      vld_p2_q     <= vld_p1_q && (state_q != IDLE);
    end
  end

  assign s_ready        = !hold_valid_q;
  assign fir_en         = (state_q != IDLE);
  assign busy           = (state_q != IDLE);
  assign fir_new_sample = nsmp_q;
  assign fir_sample     = sample_q;
  assign m_valid        = vld_p2_q;
  assign underflow      = underflow_q;

`ifdef FIR_SCHED_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [31:0] sym_cnt_q;
  logic [15:0] uf_cnt_q;
  logic        uf_evt;

  assign uf_evt = strobe && (state_q == RUN) && (phase_q == '0) && !hold_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_cnt_q <= '0;
      uf_cnt_q  <= '0;
    end else begin
      if (take)   sym_cnt_q <= sym_cnt_q + 32'd1;
      if (uf_evt) uf_cnt_q  <= sat_inc16(uf_cnt_q);
    end
  end

  assign sym_count       = sym_cnt_q;
  assign underflow_count = uf_cnt_q;
`endif

endmodule

// File: tb/tb_fir_sched.sv
// Directed bench for fir_sched at default parameters; FIR_SCHED_STATS_EN also checks the counters.
module tb_fir_sched;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               s_valid = 1'b0;
  logic signed [15:0] s_data = '0;
  logic               s_last = 1'b0;
  logic               s_ready, fir_en, fir_new_sample, m_valid, busy, underflow;
  logic signed [15:0] fir_sample;
`ifdef FIR_SCHED_STATS_EN
  logic [31:0]        sym_count;
  logic [15:0]        underflow_count;
`endif

  int total = 0;
  int bad = 0;
  int mv_cnt = 0;

  fir_sched dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_valid        (s_valid),
    .s_data         (s_data),
    .s_last         (s_last),
    .s_ready        (s_ready),
    .fir_en         (fir_en),
    .fir_new_sample (fir_new_sample),
    .fir_sample     (fir_sample),
    .m_valid        (m_valid),
    .busy           (busy),
    .underflow      (underflow)
`ifdef FIR_SCHED_STATS_EN
    ,
    .sym_count       (sym_count),
    .underflow_count (underflow_count)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (m_valid === 1'b1) mv_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ns(output int n, output logic [15:0] smp);
    n = 0;
    do begin
      step();
      n++;
    end while (fir_new_sample !== 1'b1 && n < 40);
    if (fir_new_sample !== 1'b1) begin
      total++;
      bad++;
      $error("FAIL pulse_timeout: got no fir_new_sample expected one within 40 cycles");
    end
    smp = fir_sample;
  endtask

  // Walks one burst pulse by pulse; phase-0 pulses carry ph0[], all others are zero.
  task automatic burst(input string tag, input int npulses, input logic [15:0] ph0[4],
                       input int nsym, input int inj_k, input logic [15:0] inj_data,
                       input logic inj_last, input int exp_mv, input int uf_from,
                       input int k0_n);
    int n, extra, mv0;
    logic [15:0] smp, expv;
    extra = 0;
    mv0 = mv_cnt;
    for (int k = 0; k < npulses; k++) begin
      wait_ns(n, smp);
      expv = ((k % 4) == 0 && (k / 4) < nsym) ? ph0[k/4] : 16'h0000;
      check({tag, "_sample"}, {16'h0, smp}, {16'h0, expv});
      if (k > 0) check({tag, "_interval"}, n + extra, 4);
      else if (k0_n >= 0) check({tag, "_first_interval"}, n, k0_n);
      extra = 0;
      check({tag, "_busy"}, busy, (k == npulses - 1) ? 0 : 1);
      check({tag, "_fir_en"}, fir_en, (k == npulses - 1) ? 0 : 1);
      check({tag, "_underflow"}, underflow, (k >= uf_from) ? 1 : 0);
      if (k == 3) begin
        check({tag, "_mvalid_pre"}, m_valid, 0);
        step();
        extra++;
        check({tag, "_mvalid_first"}, m_valid, 1);
      end
      if (k == inj_k) begin
        s_valid = 1'b1;
        s_data  = inj_data;
        s_last  = inj_last;
        step();
        extra++;
        s_valid = 1'b0;
        s_last  = 1'b0;
        check({tag, "_inject_ready"}, s_ready, 0);
      end
    end
    step();
    step();
    check({tag, "_mvalid_count"}, mv_cnt - mv0, exp_mv);
  endtask

  task automatic feed(input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2);
    logic [15:0] syms[3];
    syms = '{d0, d1, d2};
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = syms[i];
      s_last  = (i == 2);
      for (int t = 0; t < 60 && s_ready !== 1'b1; t++) step();
      step();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  initial begin
    int n;
    logic [15:0] smp;

    // Power-on reset
    #1 rst_n = 1'b0;
    #1;
    check("rst_s_ready", s_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_fir_en", fir_en, 0);
    check("rst_new_sample", fir_new_sample, 0);
    check("rst_sample", fir_sample, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_underflow", underflow, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("idle_busy", busy, 0);

    // Single symbol with last: 4 run + 8 flush + 3 drain strobes
    s_valid = 1'b1; s_data = 16'sh4000; s_last = 1'b1;
    step();
    s_valid = 1'b0; s_last = 1'b0;
    check("single_accept_ready", s_ready, 0);
    burst("single", 15, '{16'h4000, 16'h0, 16'h0, 16'h0}, 1, -1, 16'h0, 1'b0, 11, 1000, -1);
    check("single_ready_after", s_ready, 1);

    // Back-to-back symbols with s_valid held
    fork
      burst("b2b", 23, '{16'h4000, 16'hC000, 16'h4000, 16'h0}, 3, -1, 16'h0, 1'b0, 19, 1000, -1);
      feed(16'h4000, 16'hC000, 16'h4000);
    join

    // Asynchronous reset in the middle of RUN with s_valid asserted
    s_valid = 1'b1; s_data = 16'sh4000; s_last = 1'b0;
    wait_ns(n, smp);
    wait_ns(n, smp);
    check("midrun_busy", busy, 1);
    rst_n = 1'b0;
    #2;
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_fir_en", fir_en, 0);
    check("midrun_rst_new_sample", fir_new_sample, 0);
    check("midrun_rst_sample", fir_sample, 0);
    check("midrun_rst_m_valid", m_valid, 0);
    check("midrun_rst_s_ready", s_ready, 1);
    s_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    check("midrun_release_busy", busy, 0);
    check("midrun_release_ready", s_ready, 1);
`ifdef FIR_SCHED_STATS_EN
    check("midrun_rst_sym_count", sym_count, 0);
`endif

    // Starvation: first symbol not last, second arrives after a missed slot
    s_valid = 1'b1; s_data = 16'sh2000; s_last = 1'b0;
    step();
    s_valid = 1'b0;
    burst("starve", 23, '{16'h2000, 16'h0000, 16'h1000, 16'h0}, 3, 4, 16'h1000, 1'b1, 19, 4, -1);
`ifdef FIR_SCHED_STATS_EN
    check("stats_sym_count", sym_count, 2);
    check("stats_underflow_count", underflow_count, 1);
`endif

    // Symbol accepted mid-FLUSH waits; RUN restarts right after IDLE
    s_valid = 1'b1; s_data = 16'sh3000; s_last = 1'b1;
    step();
    s_valid = 1'b0; s_last = 1'b0;
    burst("flush", 15, '{16'h3000, 16'h0, 16'h0, 16'h0}, 1, 6, 16'h0800, 1'b1, 11, 0, -1);
    check("flush_restart_busy", busy, 1);
    burst("next", 15, '{16'h0800, 16'h0, 16'h0, 16'h0}, 1, -1, 16'h0, 1'b0, 11, 0, 3);
    check("final_underflow_sticky", underflow, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
